// File: rtl/ats_pkg.sv
// ats_pkg: shared definitions for the ATS eligibility gate.
//   TS_WIDTH_DEFAULT - default width of timer / eligibility / arrival stamps (ps)
//   ats_state_t      - gate FSM states
//   ts_reached()     - wrap-aware "now has reached target" compare
package ats_pkg;

    localparam int unsigned TS_WIDTH_DEFAULT = 72;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RELEASE,
        ST_DISCARD
    } ats_state_t;

    // Target counts as reached when (now - target), taken modulo 2^W, has a clear
    // MSB. A wrapped timer still compares correctly while both stamps are less than
    // half the timer range apart.
    function automatic logic ts_reached(
        input logic [TS_WIDTH_DEFAULT-1:0] now,
        input logic [TS_WIDTH_DEFAULT-1:0] target
    );
        logic [TS_WIDTH_DEFAULT-1:0] diff;
        diff = now - target;
        return ~diff[TS_WIDTH_DEFAULT-1];
    endfunction

endpackage

// File: rtl/ats_desc_fifo.sv
// ats_desc_fifo: synchronous first-word-fall-through FIFO holding pending frame
// entries for the eligibility gate.
//   clk, rstn  - clock, synchronous active-low reset (empties the FIFO)
//   wr_en      - push wr_data (ignored while full)
//   rd_en      - pop the entry shown on rd_data (ignored while empty)
//   rd_data    - current oldest entry
//   full/empty - occupancy flags, derived from registered pointers only
module ats_desc_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ats_eligibility_gate.sv
// ats_eligibility_gate: holds frame descriptors until the reference timer reaches
// each frame's eligibility time, then releases them in arrival order. Frames whose
// residence exceeds MAX_RESIDENCE_PS are discarded and counted instead.
//   clk, rstn            - clock, synchronous active-low reset
//   timer_i              - free-running reference time (ps)
//   gate_enable          - 0 blocks new releases; discard still evaluated
//   s_valid/s_ready      - descriptor input handshake
//   s_desc, s_elig_time  - descriptor and its eligibility time
//   m_valid/m_ready      - released descriptor handshake, m_desc payload
//   drop_valid/drop_desc - one-cycle pulse per discarded descriptor
//   drop_count           - saturating count of discards since reset
module ats_eligibility_gate
    import ats_pkg::*;
#(
    parameter int unsigned                TIMESTAMP_WIDTH  = TS_WIDTH_DEFAULT,
    parameter int unsigned                DESC_WIDTH       = 32,
    parameter int unsigned                FIFO_DEPTH       = 4,
    parameter logic [TIMESTAMP_WIDTH-1:0] MAX_RESIDENCE_PS = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [TIMESTAMP_WIDTH-1:0] timer_i,
    input  logic                       gate_enable,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DESC_WIDTH-1:0]      s_desc,
    input  logic [TIMESTAMP_WIDTH-1:0] s_elig_time,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DESC_WIDTH-1:0]      m_desc,
    output logic                       drop_valid,
    output logic [DESC_WIDTH-1:0]      drop_desc,
    output logic [31:0]                drop_count
);

    localparam int unsigned ENTRY_W = DESC_WIDTH + 2 * TIMESTAMP_WIDTH;

    ats_state_t                 state;
    logic [DESC_WIDTH-1:0]      head_desc;
    logic [TIMESTAMP_WIDTH-1:0] head_elig;
    logic [TIMESTAMP_WIDTH-1:0] head_arr;
    logic                       ready_q;

    logic                       fifo_wr;
    logic                       fifo_rd;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [ENTRY_W-1:0]         fifo_wdata;
    logic [ENTRY_W-1:0]         fifo_rdata;

    logic                       eligible;
    logic                       expired;
    logic [TIMESTAMP_WIDTH-1:0] residence;

    // ready_q keeps s_ready low for the reset cycle itself.
    assign s_ready    = ready_q && !fifo_full;
    assign fifo_wr    = s_valid && s_ready;
    assign fifo_wdata = {s_desc, s_elig_time, timer_i};
    assign fifo_rd    = (state == ST_IDLE) && !fifo_empty;

    ats_desc_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The package compare is fixed at the default width; other widths use the
    // same modular rule locally.
    generate
        if (TIMESTAMP_WIDTH == TS_WIDTH_DEFAULT) begin : g_pkg_cmp
            assign eligible = ts_reached(timer_i, head_elig);
        end else begin : g_local_cmp
            logic [TIMESTAMP_WIDTH-1:0] elig_diff;
            assign elig_diff = timer_i - head_elig;
            assign eligible  = ~elig_diff[TIMESTAMP_WIDTH-1];
        end
    endgenerate

    assign residence = timer_i - head_arr;
    assign expired   = (MAX_RESIDENCE_PS != '0) && (residence > MAX_RESIDENCE_PS);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            ready_q    <= 1'b0;
            head_desc  <= '0;
            head_elig  <= '0;
            head_arr   <= '0;
            m_valid    <= 1'b0;
            m_desc     <= '0;
            drop_valid <= 1'b0;
            drop_desc  <= '0;
            drop_count <= '0;
        end else begin
            ready_q    <= 1'b1;
            drop_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {head_desc, head_elig, head_arr} <= fifo_rdata;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Expiry wins over eligibility in the same cycle.
                    if (expired) begin
                        drop_valid <= 1'b1;
                        drop_desc  <= head_desc;
                        if (drop_count != '1) drop_count <= drop_count + 32'd1;
                        state <= ST_DISCARD;
                    end else if (eligible && gate_enable) begin
                        m_valid <= 1'b1;
                        m_desc  <= head_desc;
                        state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ats_eligibility_gate.sv
// tb_ats_eligibility_gate: scoreboard bench for ats_eligibility_gate.
// dut uses MAX_RESIDENCE_PS=0 (no discard); dut_d uses 40000 ps for discard scenarios.
module tb_ats_eligibility_gate;

    localparam int unsigned    TW    = 72;
    localparam int unsigned    DW    = 32;
    localparam logic [TW-1:0]  STEP  = 72'd8000;
    localparam int unsigned    DMAX  = 40000;

    logic          clk         = 1'b0;
    logic          rstn        = 1'b0;
    logic          gate_enable = 1'b1;
    logic [TW-1:0] timer       = '0;

    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_desc  = '0;
    logic [TW-1:0] s_elig  = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_desc;
    logic          drop_valid;
    logic [DW-1:0] drop_desc;
    logic [31:0]   drop_count;

    logic          s_valid_d = 1'b0;
    logic          s_ready_d;
    logic [DW-1:0] s_desc_d  = '0;
    logic [TW-1:0] s_elig_d  = '0;
    logic          m_valid_d;
    logic          m_ready_d = 1'b0;
    logic [DW-1:0] m_desc_d;
    logic          drop_valid_d;
    logic [DW-1:0] drop_desc_d;
    logic [31:0]   drop_count_d;

    int unsigned   tests_run    = 0;
    int unsigned   tests_failed = 0;
    int unsigned   cyc          = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_drop_q[$];

    ats_eligibility_gate #(
        .TIMESTAMP_WIDTH  (TW),
        .DESC_WIDTH       (DW),
        .FIFO_DEPTH       (4),
        .MAX_RESIDENCE_PS (72'd0)
    ) dut (
        .clk (clk), .rstn (rstn), .timer_i (timer), .gate_enable (gate_enable),
        .s_valid (s_valid), .s_ready (s_ready), .s_desc (s_desc), .s_elig_time (s_elig),
        .m_valid (m_valid), .m_ready (m_ready), .m_desc (m_desc),
        .drop_valid (drop_valid), .drop_desc (drop_desc), .drop_count (drop_count)
    );

    ats_eligibility_gate #(
        .TIMESTAMP_WIDTH  (TW),
        .DESC_WIDTH       (DW),
        .FIFO_DEPTH       (4),
        .MAX_RESIDENCE_PS (72'd40000)
    ) dut_d (
        .clk (clk), .rstn (rstn), .timer_i (timer), .gate_enable (gate_enable),
        .s_valid (s_valid_d), .s_ready (s_ready_d), .s_desc (s_desc_d), .s_elig_time (s_elig_d),
        .m_valid (m_valid_d), .m_ready (m_ready_d), .m_desc (m_desc_d),
        .drop_valid (drop_valid_d), .drop_desc (drop_desc_d), .drop_count (drop_count_d)
    );

    initial forever #5 clk = ~clk;

    // Advance one cycle; inputs and timer change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        timer = timer + STEP;
        cyc++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_s_ready: got %0b expected 0", s_ready);
        end
        tests_run++;
        if ({m_valid, m_desc} !== '0) begin
            tests_failed++; $display("FAIL reset_m: got valid=%0b desc=%h expected 0/0", m_valid, m_desc);
        end
        tests_run++;
        if ({drop_valid, drop_desc, drop_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_drop: got v=%0b d=%h c=%0d expected 0", drop_valid, drop_desc, drop_count);
        end
        rstn = 1'b1;
        tick();
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_release_s_ready: got %0b expected 1", s_ready);
        end
    endtask

    task automatic test_past();
        int unsigned   k;
        int unsigned   extra;
        logic [DW-1:0] expd;
        m_ready = 1'b1;
        s_desc  = 32'hA5A5_0001;
        s_elig  = timer - STEP;
        s_valid = 1'b1;
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++; $display("FAIL past_s_ready: got %0b expected 1", s_ready);
        end
        exp_q.push_back(s_desc);
        k = cyc;
        tick();
        s_valid = 1'b0;
        while (m_valid !== 1'b1 && (cyc - k) < 20) tick();
        tests_run++;
        if ((cyc - k) != 3) begin
            tests_failed++; $display("FAIL past_latency: got %0d cycles expected 3", cyc - k);
        end
        expd = exp_q.pop_front();
        tests_run++;
        if (m_valid !== 1'b1 || m_desc !== expd) begin
            tests_failed++; $display("FAIL past_desc: got v=%0b %h expected 1 %h", m_valid, m_desc, expd);
        end
        extra = 0;
        repeat (5) begin
            tick();
            if (m_valid) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++; $display("FAIL past_single_transfer: got %0d extra valid cycles expected 0", extra);
        end
    endtask

    task automatic test_future();
        int unsigned   k;
        logic [TW-1:0] elig;
        logic [DW-1:0] expd;
        m_ready = 1'b1;
        elig    = timer + 72'd80000;
        s_desc  = 32'hF00D_0002;
        s_elig  = elig;
        s_valid = 1'b1;
        exp_q.push_back(s_desc);
        k = cyc;
        tick();
        s_valid = 1'b0;
        while (m_valid !== 1'b1 && (cyc - k) < 40) tick();
        // 10 steps to reach elig, one more for the registered output
        tests_run++;
        if ((cyc - k) != 80000 / 8000 + 1) begin
            tests_failed++; $display("FAIL future_latency: got %0d cycles expected %0d", cyc - k, 80000 / 8000 + 1);
        end
        tests_run++;
        if (timer - elig != STEP) begin
            tests_failed++; $display("FAIL future_timer_at_release: got timer-elig=%0d expected %0d", timer - elig, STEP);
        end
        expd = exp_q.pop_front();
        tests_run++;
        if (m_desc !== expd) begin
            tests_failed++; $display("FAIL future_desc: got %h expected %h", m_desc, expd);
        end
        tick();
    endtask

    task automatic test_gate();
        int unsigned   bad;
        logic [DW-1:0] expd;
        m_ready     = 1'b0;
        gate_enable = 1'b0;
        s_desc      = 32'h6A7E_0003;
        s_elig      = timer - STEP;
        s_valid     = 1'b1;
        exp_q.push_back(s_desc);
        tick();
        s_valid = 1'b0;
        bad = 0;
        repeat (8) begin
            if (m_valid) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL gate_blocked: got %0d valid cycles expected 0", bad);
        end
        gate_enable = 1'b1;
        tick();
        tests_run++;
        if (m_valid !== 1'b1) begin
            tests_failed++; $display("FAIL gate_open: got m_valid=%0b expected 1", m_valid);
        end
        gate_enable = 1'b0;
        bad = 0;
        repeat (3) begin
            tick();
            if (m_valid !== 1'b1 || m_desc !== 32'h6A7E_0003) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL gate_release_held: got %0d unstable cycles expected 0", bad);
        end
        m_ready = 1'b1;
        expd    = exp_q.pop_front();
        tests_run++;
        if (m_valid !== 1'b1 || m_desc !== expd) begin
            tests_failed++; $display("FAIL gate_desc: got v=%0b %h expected 1 %h", m_valid, m_desc, expd);
        end
        tick();
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++; $display("FAIL gate_handshake_done: got m_valid=%0b expected 0", m_valid);
        end
        gate_enable = 1'b1;
    endtask

    task automatic test_order();
        int unsigned   k;
        int unsigned   got;
        int unsigned   first;
        logic [DW-1:0] expd;
        m_ready = 1'b1;
        s_desc  = 32'h0DE0_000A;
        s_elig  = timer + 72'd80000;
        s_valid = 1'b1;
        exp_q.push_back(s_desc);
        k = cyc;
        tick();
        s_desc = 32'h0DE0_000B;
        s_elig = timer - STEP;
        exp_q.push_back(s_desc);
        tick();
        s_valid = 1'b0;
        got   = 0;
        first = 0;
        while (got < 2 && (cyc - k) < 40) begin
            if (m_valid && m_ready) begin
                if (got == 0) first = cyc - k;
                expd = exp_q.pop_front();
                tests_run++;
                if (m_desc !== expd) begin
                    tests_failed++; $display("FAIL order_desc%0d: got %h expected %h", got, m_desc, expd);
                end
                got++;
            end
            tick();
        end
        tests_run++;
        if (got != 2 || first != 11) begin
            tests_failed++; $display("FAIL order_blocking: got %0d outputs first at %0d expected 2 at 11", got, first);
        end
    endtask

    task automatic test_backpressure();
        int unsigned   got;
        int unsigned   waited;
        logic [DW-1:0] expd;
        bit            hs_seen;
        bit            early_ready;
        bit            accepted;
        m_ready     = 1'b0;
        hs_seen     = 1'b0;
        early_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            s_desc  = 32'hB000_0000 + i;
            s_elig  = timer - STEP;
            s_valid = 1'b1;
            tests_run++;
            if (s_ready !== 1'b1) begin
                tests_failed++; $display("FAIL bp_accept%0d: got s_ready=%0b expected 1", i, s_ready);
            end
            exp_q.push_back(s_desc);
            tick();
        end
        s_desc = 32'hB000_0005;
        s_elig = timer - STEP;
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++; $display("FAIL bp_full: got s_ready=%0b expected 0", s_ready);
        end
        repeat (4) begin
            tick();
            if (s_ready) early_ready = 1'b1;
        end
        m_ready = 1'b1;
        got     = 0;
        waited  = 0;
        while (got < 6 && waited < 80) begin
            accepted = 1'b0;
            if (s_valid && s_ready) begin
                if (!hs_seen) early_ready = 1'b1;
                exp_q.push_back(s_desc);
                accepted = 1'b1;
            end
            if (m_valid && m_ready) begin
                hs_seen = 1'b1;
                expd    = exp_q.pop_front();
                tests_run++;
                if (m_desc !== expd) begin
                    tests_failed++; $display("FAIL bp_order%0d: got %h expected %h", got, m_desc, expd);
                end
                got++;
            end
            tick();
            waited++;
            if (accepted) s_valid = 1'b0;
        end
        tests_run++;
        if (got != 6) begin
            tests_failed++; $display("FAIL bp_count: got %0d outputs expected 6", got);
        end
        tests_run++;
        if (early_ready) begin
            tests_failed++; $display("FAIL bp_ready_early: got s_ready=1 before first handshake expected 0");
        end
        s_valid = 1'b0;
    endtask

    task automatic test_wrap();
        int unsigned   offs [2] = '{16000, 64000};
        int unsigned   k;
        logic [TW-1:0] offv;
        logic [DW-1:0] expd;
        m_ready = 1'b1;
        foreach (offs[j]) begin
            offv    = TW'(offs[j]);
            timer   = {TW{1'b0}} - offv;
            s_desc  = 32'h3A90_0000 + j;
            s_elig  = 72'd8000;
            s_valid = 1'b1;
            exp_q.push_back(s_desc);
            k = cyc;
            tick();
            s_valid = 1'b0;
            while (m_valid !== 1'b1 && (cyc - k) < 30) tick();
            tests_run++;
            if ((cyc - k) != offs[j] / 8000 + 2) begin
                tests_failed++;
                $display("FAIL wrap_latency%0d: got %0d cycles expected %0d", j, cyc - k, offs[j] / 8000 + 2);
            end
            expd = exp_q.pop_front();
            tests_run++;
            if (m_desc !== expd) begin
                tests_failed++; $display("FAIL wrap_desc%0d: got %h expected %h", j, m_desc, expd);
            end
            tick();
        end
    endtask

    task automatic test_discard();
        int unsigned   k;
        int unsigned   pulses;
        int unsigned   mv;
        int unsigned   first;
        logic [DW-1:0] expd;
        m_ready_d = 1'b1;
        tests_run++;
        if (drop_count_d !== 32'd0) begin
            tests_failed++; $display("FAIL discard_count_before: got %0d expected 0", drop_count_d);
        end
        s_desc_d  = 32'hD15C_A4D0;
        s_elig_d  = timer + 72'd200000;
        s_valid_d = 1'b1;
        exp_drop_q.push_back(s_desc_d);
        k = cyc;
        tick();
        s_valid_d = 1'b0;
        pulses = 0;
        mv     = 0;
        first  = 0;
        repeat (35) begin
            if (m_valid_d) mv++;
            if (drop_valid_d) begin
                if (pulses == 0) first = cyc - k;
                pulses++;
                expd = (exp_drop_q.size() > 0) ? exp_drop_q.pop_front() : '1;
                tests_run++;
                if (drop_desc_d !== expd) begin
                    tests_failed++; $display("FAIL discard_desc: got %h expected %h", drop_desc_d, expd);
                end
            end
            tick();
        end
        // residence first exceeds DMAX after 6 steps; +1 for the registered pulse
        tests_run++;
        if (pulses != 1 || first != DMAX / 8000 + 2) begin
            tests_failed++;
            $display("FAIL discard_pulse: got %0d pulses at %0d expected 1 at %0d", pulses, first, DMAX / 8000 + 2);
        end
        tests_run++;
        if (drop_count_d !== 32'd1) begin
            tests_failed++; $display("FAIL discard_count: got %0d expected 1", drop_count_d);
        end
        tests_run++;
        if (mv != 0) begin
            tests_failed++; $display("FAIL discard_no_release: got %0d valid cycles expected 0", mv);
        end
    endtask

    task automatic test_reset_mid_release();
        int unsigned   k;
        int unsigned   bad;
        logic [DW-1:0] expd;
        m_ready = 1'b0;
        s_desc  = 32'h5EAD_0007;
        s_elig  = timer - STEP;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        k = cyc;
        while (m_valid !== 1'b1 && (cyc - k) < 20) tick();
        tests_run++;
        if (m_valid !== 1'b1) begin
            tests_failed++; $display("FAIL rmr_reach_release: got m_valid=%0b expected 1", m_valid);
        end
        rstn = 1'b0;
        tick();
        tests_run++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
            tests_failed++; $display("FAIL rmr_outputs: got m_valid=%0b s_ready=%0b expected 0 0", m_valid, s_ready);
        end
        tests_run++;
        if (drop_count !== 32'd0 || drop_valid !== 1'b0 || drop_count_d !== 32'd0) begin
            tests_failed++;
            $display("FAIL rmr_drop: got cnt=%0d v=%0b cnt_d=%0d expected 0 0 0", drop_count, drop_valid, drop_count_d);
        end
        exp_q.delete();
        rstn = 1'b1;
        tick();
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rmr_s_ready: got %0b expected 1", s_ready);
        end
        bad = 0;
        repeat (4) begin
            tick();
            if (m_valid || drop_valid) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL rmr_stale_head: got %0d active cycles expected 0", bad);
        end
        m_ready = 1'b1;
        s_desc  = 32'hF4E5_0008;
        s_elig  = timer - STEP;
        s_valid = 1'b1;
        exp_q.push_back(s_desc);
        k = cyc;
        tick();
        s_valid = 1'b0;
        while (m_valid !== 1'b1 && (cyc - k) < 20) tick();
        expd = exp_q.pop_front();
        tests_run++;
        if ((cyc - k) != 3 || m_desc !== expd) begin
            tests_failed++;
            $display("FAIL rmr_fresh: got lat=%0d desc=%h expected 3 %h", cyc - k, m_desc, expd);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_past();
        test_future();
        test_gate();
        test_order();
        test_backpressure();
        test_wrap();
        test_discard();
        test_reset_mid_release();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
